// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive path: drain FSM encoding,
// control-register bit map and receiver baud limits.
package rs232_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CTL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_state_e;

    localparam int unsigned CTL_FSEL    = 0;
    localparam int unsigned CTL_CLR_OVR = 1;
    localparam int unsigned CTL_FLUSH   = 2;
    localparam int unsigned CTL_IE      = 3;

    // Bit-period limits in 25 MHz clocks for the two supported baud rates
    localparam int unsigned CLK_HZ        = 25_000_000;
    localparam int unsigned LIM_115200    = CLK_HZ / 115_200;
    localparam int unsigned LIM_230400    = CLK_HZ / 230_400;
    localparam int unsigned LIM_115200_HF = LIM_115200 / 2;
    localparam int unsigned LIM_230400_HF = LIM_230400 / 2;

endpackage

// File: rtl/rs232_rx_fifo.sv
// DEPTH x 8 synchronous FIFO with flush, occupancy count and a registered
// head byte that reads as zero when empty.
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [AW:0]       count
);

    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nx;
    logic [CW-1:0]     count_nx;
    logic [DATA_W-1:0] head_nx;
    logic              pop_ok;
    logic              bypass;

    // Next occupancy and next head; a push landing in the slot that becomes
    // the head this cycle is forwarded straight from wdata.
    always_comb begin
        pop_ok    = pop && (count != '0);
        rd_ptr_nx = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        count_nx  = count;
        if (push && !pop_ok) begin
            count_nx = count + CW'(1);
        end else if (!push && pop_ok) begin
            count_nx = count - CW'(1);
        end
        bypass  = push && ((count == '0) || (pop_ok && (count == CW'(1))));
        head_nx = '0;
        if (flush) begin
            count_nx = '0;
        end else if (count_nx != '0) begin
            head_nx = bypass ? wdata : mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
        end else begin
            count <= count_nx;
            head  <= head_nx;
            valid <= (count_nx != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr_nx;
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rs232_rx_ctrl.sv
// Receive-side controller: drains receiver bytes via rdy/done into a FIFO
// and exposes data, status and control registers to the CPU bus.
module rs232_rx_ctrl
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_fsel,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [CTL_W-1:0]  io_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output logic [AW:0]       count,
    output logic              overrun,
    output logic              irq
);

    localparam int unsigned CW = AW + 1;

    rx_state_e state;
    logic      ie;
    logic      capture;
    logic      flush;
    logic      room;
    logic      push;
    logic      drop;

    // A full FIFO still has room when the CPU pops in the same cycle
    always_comb begin
        capture = (state == IDLE) && rx_rdy;
        flush   = io_wr && io_wdata[CTL_FLUSH];
        room    = (count < CW'(DEPTH)) || (io_rd && valid);
        push    = capture && !flush && room;
        drop    = capture && !flush && !room;
    end

    rs232_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (io_rd),
        .flush (flush),
        .wdata (rx_data),
        .head  (rd_data),
        .valid (valid),
        .count (count)
    );

    // Drain handshake; WAIT holds until rx_rdy falls so a byte is taken once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rx_done <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        state   <= ACK;
                        rx_done <= 1'b1;
                    end
                end
                ACK:  state <= WAIT;
                WAIT: begin
                    if (!rx_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_fsel <= 1'b0;
            ie      <= 1'b0;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            irq <= valid && ie;
            if (io_wr) begin
                rx_fsel <= io_wdata[CTL_FSEL];
                ie      <= io_wdata[CTL_IE];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (io_wr && io_wdata[CTL_CLR_OVR]) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
